// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared constants for the GPIO port family: synchroniser depth limits,
// default port width and the I/O-space register offsets used by the decoder.
// -----------------------------------------------------------------------------
package gpio_pkg;

    localparam int unsigned SYNC_STAGES_MIN    = 2;
    localparam int unsigned SYNC_STAGES_MAX    = 4;
    localparam int unsigned GPIO_WIDTH_DEFAULT = 8;

    // Register offsets within one port's I/O window
    typedef enum logic [2:0] {
        GPIO_OFS_PINX  = 3'd0,
        GPIO_OFS_DDRX  = 3'd1,
        GPIO_OFS_PORTX = 3'd2,
        GPIO_OFS_PCMSK = 3'd3,
        GPIO_OFS_PCICR = 3'd4,
        GPIO_OFS_PCIFR = 3'd5
    } gpio_reg_ofs_e;

    // Clamp a requested synchroniser depth into the supported range
    function automatic int unsigned gpio_clamp_stages(input int unsigned req);
        if (req < SYNC_STAGES_MIN)      return SYNC_STAGES_MIN;
        else if (req > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        else                            return req;
    endfunction

endpackage

// File: rtl/gpio_synchronizer.sv
// -----------------------------------------------------------------------------
// gpio_synchronizer
// Multi-bit flop chain bringing asynchronous pad levels into the clk domain.
// All stages reset to 0.
// Ports:
//   i_clk    in  1      clock
//   i_clr_n  in  1      asynchronous active-low reset
//   i_async  in  WIDTH  raw asynchronous input
//   o_sync   out WIDTH  last synchroniser stage
// -----------------------------------------------------------------------------
module gpio_synchronizer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_port_pcint.sv
// -----------------------------------------------------------------------------
// gpio_port_pcint
// GPIO port: DDRx/PORTx/PINx registers, pad synchroniser, masked pin-change
// detection, sticky change flag and gated interrupt request.
// Optional feature macro: GPIO_PIN_TOGGLE_EN (PINx write toggles PORTx bits).
// Ports:
//   clk, clr_n            clock, asynchronous active-low reset
//   write_data            shared register write bus
//   DDRx/PORTx/PINx/PCMSK/PCIE_write_enable   register write strobes
//   pcif_clear            clear sticky pin-change flag
//   pad_in                raw pad levels
//   DDRx/PORTx/PINx/PCMSK_output, pcie, pcif, irq   register views / interrupt
// -----------------------------------------------------------------------------
module gpio_port_pcint
    import gpio_pkg::*;
#(
    parameter int unsigned       WIDTH        = GPIO_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]  DDRX_DEFAULT = '0,
    parameter int unsigned       SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] write_data,
    input  logic             DDRx_write_enable,
    input  logic             PORTx_write_enable,
    input  logic             PINx_write_enable,
    input  logic             PCMSK_write_enable,
    input  logic             PCIE_write_enable,
    input  logic             pcif_clear,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] DDRx_output,
    output logic [WIDTH-1:0] PORTx_output,
    output logic [WIDTH-1:0] PINx_output,
    output logic [WIDTH-1:0] PCMSK_output,
    output logic             pcie,
    output logic             pcif,
    output logic             irq
);

    localparam int unsigned STAGES = gpio_clamp_stages(SYNC_STAGES);

    logic [WIDTH-1:0] r_ddr;
    logic [WIDTH-1:0] r_port;
    logic [WIDTH-1:0] r_pcmsk;
    logic [WIDTH-1:0] r_prev;
    logic             r_pcie;
    logic             r_pcif;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_chg;

    gpio_synchronizer #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_clr_n (clr_n),
        .i_async (pad_in),
        .o_sync  (w_sync_q)
    );

`ifndef GPIO_PIN_TOGGLE_EN
    logic w_unused_pin_we;
    assign w_unused_pin_we = PINx_write_enable;
`endif

    // Output bits never contribute to change detection
    assign w_chg = (w_sync_q ^ r_prev) & r_pcmsk & ~r_ddr;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ddr   <= DDRX_DEFAULT;
            r_port  <= '0;
            r_pcmsk <= '0;
            r_prev  <= '0;
            r_pcie  <= 1'b0;
            r_pcif  <= 1'b0;
        end else begin
            if (DDRx_write_enable)  r_ddr   <= write_data;
            if (PCMSK_write_enable) r_pcmsk <= write_data;
            if (PCIE_write_enable)  r_pcie  <= write_data[0];

            // r_ddr here is the pre-edge value, even when DDRx is written this edge
            if (PORTx_write_enable) begin
                r_port <= write_data & r_ddr;
`ifdef GPIO_PIN_TOGGLE_EN
            end else if (PINx_write_enable) begin
                r_port <= r_port ^ (write_data & r_ddr);
`endif
            end

            r_prev <= w_sync_q;

            // A new change on the clearing edge wins so no event is lost
            if (|w_chg)          r_pcif <= 1'b1;
            else if (pcif_clear) r_pcif <= 1'b0;
        end
    end

    assign DDRx_output  = r_ddr;
    assign PORTx_output = r_port;
    assign PINx_output  = w_sync_q & ~r_ddr;
    assign PCMSK_output = r_pcmsk;
    assign pcie         = r_pcie;
    assign pcif         = r_pcif;
    assign irq          = r_pcif & r_pcie;

endmodule

// File: tb/tb_gpio_port_pcint.sv
module tb_gpio_port_pcint;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] write_data;
    logic       ddr_we, port_we, pin_we, msk_we, pcie_we, clr;
    logic [7:0] pad;
    logic [7:0] ddr_o, port_o, pin_o, msk_o;
    logic       pcie_o, pcif_o, irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_port_pcint #(
        .WIDTH        (8),
        .DDRX_DEFAULT (8'h0F),
        .SYNC_STAGES  (2)
    ) dut (
        .clk                (clk),
        .clr_n              (clr_n),
        .write_data         (write_data),
        .DDRx_write_enable  (ddr_we),
        .PORTx_write_enable (port_we),
        .PINx_write_enable  (pin_we),
        .PCMSK_write_enable (msk_we),
        .PCIE_write_enable  (pcie_we),
        .pcif_clear         (clr),
        .pad_in             (pad),
        .DDRx_output        (ddr_o),
        .PORTx_output       (port_o),
        .PINx_output        (pin_o),
        .PCMSK_output       (msk_o),
        .pcie               (pcie_o),
        .pcif               (pcif_o),
        .irq                (irq_o)
    );

    typedef struct {
        logic       ddr_we, port_we, msk_we, pcie_we, clr;
        logic [7:0] wdata, pad;
        logic [7:0] e_ddr, e_port, e_pin, e_msk;
        logic       e_pcie, e_pcif, e_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        ddr_we = 0; port_we = 0; pin_we = 0; msk_we = 0; pcie_we = 0; clr = 0;
        write_data = '0;
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".ddr"},  {24'd0, ddr_o},  {24'd0, v.e_ddr});
        check({tag, ".port"}, {24'd0, port_o}, {24'd0, v.e_port});
        check({tag, ".pin"},  {24'd0, pin_o},  {24'd0, v.e_pin});
        check({tag, ".msk"},  {24'd0, msk_o},  {24'd0, v.e_msk});
        check({tag, ".pcie"}, {31'd0, pcie_o}, {31'd0, v.e_pcie});
        check({tag, ".pcif"}, {31'd0, pcif_o}, {31'd0, v.e_pcif});
        check({tag, ".irq"},  {31'd0, irq_o},  {31'd0, v.e_irq});
    endtask

    initial begin
        vec_t v;
        // ddr port msk pcie clr wdata pad | ddr port pin msk pcie pcif irq
        tbl.push_back('{1,1,0,0,0, 8'hFF, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00, 0,0,0}); // same-edge DDR+PORT
        tbl.push_back('{1,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 0,0,0});
        tbl.push_back('{0,0,1,1,0, 8'h01, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01, 1,0,0});
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h00, 8'h01, 1,0,0}); // pad0 rises
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h01, 8'h01, 1,0,0});
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h01, 8'h01, 1,1,1});
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h01, 8'h01, 1,1,1}); // sticky
        tbl.push_back('{0,0,0,0,1, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h01, 8'h01, 1,0,0}); // clear
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h01, 8'h01, 1,0,0}); // pad0 falls
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01, 1,0,0});
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01, 1,1,1});
        tbl.push_back('{0,0,0,1,0, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01, 0,1,0}); // pcie off
        tbl.push_back('{0,0,0,0,1, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01, 0,0,0});
        tbl.push_back('{0,0,1,0,0, 8'h00, 8'hAA, 8'h00, 8'h0F, 8'h00, 8'h00, 0,0,0}); // mask all off
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'hAA, 8'h00, 8'h0F, 8'hAA, 8'h00, 0,0,0});
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h55, 8'h00, 8'h0F, 8'hAA, 8'h00, 0,0,0});
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h55, 8'h00, 8'h0F, 8'h55, 8'h00, 0,0,0});
        tbl.push_back('{1,0,0,0,0, 8'hFF, 8'h55, 8'hFF, 8'h0F, 8'h00, 8'h00, 0,0,0}); // all outputs
        tbl.push_back('{1,0,0,0,0, 8'h00, 8'h55, 8'h00, 8'h0F, 8'h55, 8'h00, 0,0,0});
        tbl.push_back('{0,0,1,0,0, 8'hFF, 8'h55, 8'h00, 8'h0F, 8'h55, 8'hFF, 0,0,0}); // unmask steady
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h55, 8'h00, 8'h0F, 8'h55, 8'hFF, 0,0,0});
        tbl.push_back('{1,0,0,0,0, 8'h01, 8'h54, 8'h01, 8'h0F, 8'h54, 8'hFF, 0,0,0}); // bit0 output
        tbl.push_back('{1,0,0,0,0, 8'h00, 8'h54, 8'h00, 8'h0F, 8'h54, 8'hFF, 0,0,0}); // back to input
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h54, 8'h00, 8'h0F, 8'h54, 8'hFF, 0,1,0});
        tbl.push_back('{0,0,0,0,1, 8'h00, 8'h54, 8'h00, 8'h0F, 8'h54, 8'hFF, 0,0,0});
        tbl.push_back('{0,0,0,0,0, 8'h00, 8'h54, 8'h00, 8'h0F, 8'h54, 8'hFF, 0,0,0}); // flagged once

        idle();
        pad   = 8'h00;
        clr_n = 1'b0;
        #12;
        v = '{0,0,0,0,0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 0,0,0};
        check_all("reset", v);
        @(posedge clk); #1;
        clr_n = 1'b1;

        foreach (tbl[i]) begin
            idle();
            ddr_we     = tbl[i].ddr_we;
            port_we    = tbl[i].port_we;
            msk_we     = tbl[i].msk_we;
            pcie_we    = tbl[i].pcie_we;
            clr        = tbl[i].clr;
            write_data = tbl[i].wdata;
            pad        = tbl[i].pad;
            step();
            check_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Clear on the same edge a new change sets the flag: set wins
        idle(); pcie_we = 1; write_data = 8'h01; pad = 8'h56;
        step(); idle();
        check("sw.pcie", {31'd0, pcie_o}, 32'd1);
        step(); step();
        check("sw.first_pcif", {31'd0, pcif_o}, 32'd1);
        check("sw.first_irq",  {31'd0, irq_o},  32'd1);
        pad = 8'h54;
        step(); step();
        check("sw.hold", {31'd0, pcif_o}, 32'd1);
        clr = 1; step();
        check("sw.set_wins", {31'd0, pcif_o}, 32'd1);
        step(); idle();
        check("sw.cleared", {31'd0, pcif_o}, 32'd0);
        check("sw.irq_low", {31'd0, irq_o},  32'd0);

        // PINx write: toggle with the feature, ignored without it
        ddr_we = 1; write_data = 8'hFF; step(); idle();
        port_we = 1; write_data = 8'h0F; step(); idle();
        check("tg.port_load", {24'd0, port_o}, 32'h0F);
        pin_we = 1; write_data = 8'hFF; step(); idle();
`ifdef GPIO_PIN_TOGGLE_EN
        check("tg.toggle", {24'd0, port_o}, 32'hF0);
`else
        check("tg.toggle", {24'd0, port_o}, 32'h0F);
`endif
        pin_we = 1; port_we = 1; write_data = 8'h33; step(); idle();
        check("tg.load_wins", {24'd0, port_o}, 32'h33);

        // Mid-operation asynchronous reset drops a pending flag
        ddr_we = 1; write_data = 8'h00; step(); idle();
        pad = 8'h56;
        step(); step(); step();
        check("rst.pre_pcif", {31'd0, pcif_o}, 32'd1);
        #2 clr_n = 1'b0;
        #1;
        v = '{0,0,0,0,0, 8'h00, 8'h56, 8'h0F, 8'h00, 8'h00, 8'h00, 0,0,0};
        check_all("rst_mid", v);
        @(posedge clk); #1;
        clr_n = 1'b1;
        step(); step();
        check("rst.pin_after", {24'd0, pin_o}, 32'h50);
        check("rst.pcif_after", {31'd0, pcif_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
